// File: rtl/count_wrap_tracker_pkg.sv
// Shared constants and FSM encoding for the count wrap tracker.
// Parameter defaults for the tracker and its prediction logic come from here.
package count_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MIN = 2;
    localparam int unsigned CNT_MAX = 10;

    typedef enum logic [1:0] {IDLE, SYNC, TRACK, ERROR} trk_state_t;

endpackage

// File: rtl/count_wrap_tracker_if.sv
// Observation bus between the up/down counter side and the wrap tracker.
// The master drives counter activity; the slave (tracker) returns status.
interface count_wrap_tracker_if
    import count_pkg::*;
#(
    parameter int unsigned WIDTH  = CNT_W,
    parameter int unsigned WRAP_W = 8
);
    logic              cnt_resetn;
    logic              load;
    logic              up_down;
    logic [WIDTH-1:0]  din;
    logic [WIDTH-1:0]  count;
    logic              clear;

    logic [WIDTH-1:0]  expected;
    logic              wrap_up;
    logic              wrap_dn;
    logic              step_err;
    logic              range_err;
    logic              err_sticky;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [1:0]        state;

    modport master (
        output cnt_resetn, load, up_down, din, count, clear,
        input  expected, wrap_up, wrap_dn, step_err, range_err, err_sticky, wrap_cnt, state
    );

    modport slave (
        input  cnt_resetn, load, up_down, din, count, clear,
        output expected, wrap_up, wrap_dn, step_err, range_err, err_sticky, wrap_cnt, state
    );
endinterface

// File: rtl/count_wrap_tracker_predict.sv
// Next-count function of the loadable up/down counter, evaluated on the
// control and count values the counter sampled at the previous edge.
module count_predict
    import count_pkg::*;
#(
    parameter int unsigned WIDTH   = CNT_W,
    parameter int unsigned MIN_VAL = CNT_MIN,
    parameter int unsigned MAX_VAL = CNT_MAX
) (
    input  logic [WIDTH-1:0] prev,
    input  logic             load_q,
    input  logic             ud_q,
    input  logic [WIDTH-1:0] din_q,
    output logic [WIDTH-1:0] expected
);
    localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);

    always_comb begin
        expected = din_q;
        if (load_q) begin
            if (ud_q) begin
                expected = (prev == MAX_L) ? MIN_L : prev + WIDTH'(1);
            end else begin
                expected = (prev == MIN_L) ? MAX_L : prev - WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/count_wrap_tracker.sv
// Shadows the loadable up/down counter: predicts each count, flags step and
// range errors and wrap events, and keeps a saturating wrap tally.
module count_wrap_tracker
    import count_pkg::*;
#(
    parameter int unsigned WIDTH   = CNT_W,
    parameter int unsigned MIN_VAL = CNT_MIN,
    parameter int unsigned MAX_VAL = CNT_MAX,
    parameter int unsigned WRAP_W  = 8
) (
    input logic                 clock,
    input logic                 reset,
    count_wrap_tracker_if.slave trk
);
    localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);

    trk_state_t        state_q, state_d;
    logic [WIDTH-1:0]  prev_count_q, prev_count_d;
    logic [WIDTH-1:0]  din_q, din_d;
    logic              load_q, load_d;
    logic              ud_q, ud_d;
    logic              wrap_up_q, wrap_up_d;
    logic              wrap_dn_q, wrap_dn_d;
    logic              step_err_q, step_err_d;
    logic              range_err_q, range_err_d;
    logic              err_sticky_q, err_sticky_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0]  pred;
    logic              chk_step, chk_range, chk_wup, chk_wdn;

    count_predict #(
        .WIDTH   (WIDTH),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL)
    ) u_predict (
        .prev     (prev_count_q),
        .load_q   (load_q),
        .ud_q     (ud_q),
        .din_q    (din_q),
        .expected (pred)
    );

    always_comb begin
        prev_count_d = trk.count;
        load_d       = trk.load;
        ud_d         = trk.up_down;
        din_d        = trk.din;
        state_d      = state_q;
        wrap_up_d    = 1'b0;
        wrap_dn_d    = 1'b0;
        step_err_d   = 1'b0;
        range_err_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        wrap_cnt_d   = wrap_cnt_q;

        chk_step  = (trk.count != pred);
        chk_range = (trk.count < MIN_L) || (trk.count > MAX_L);
        chk_wup   = load_q &&  ud_q && (prev_count_q == MAX_L) && (trk.count == MIN_L);
        chk_wdn   = load_q && !ud_q && (prev_count_q == MIN_L) && (trk.count == MAX_L);

        // clear outranks everything; ERROR is held through counter resets
        if (trk.clear) begin
            state_d      = IDLE;
            err_sticky_d = 1'b0;
            wrap_cnt_d   = '0;
        end else if (!trk.cnt_resetn && state_q != ERROR) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = SYNC;
                SYNC:  state_d = TRACK;
                TRACK: begin
                    step_err_d  = chk_step;
                    range_err_d = chk_range;
                    wrap_up_d   = chk_wup;
                    wrap_dn_d   = chk_wdn;
                    if (chk_step || chk_range) begin
                        state_d      = ERROR;
                        err_sticky_d = 1'b1;
                    end
                    if ((chk_wup || chk_wdn) && wrap_cnt_q != '1) begin
                        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                    end
                end
                ERROR:   state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_count_q <= '0;
            din_q        <= '0;
            load_q       <= 1'b0;
            ud_q         <= 1'b0;
            wrap_up_q    <= 1'b0;
            wrap_dn_q    <= 1'b0;
            step_err_q   <= 1'b0;
            range_err_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            din_q        <= din_d;
            load_q       <= load_d;
            ud_q         <= ud_d;
            wrap_up_q    <= wrap_up_d;
            wrap_dn_q    <= wrap_dn_d;
            step_err_q   <= step_err_d;
            range_err_q  <= range_err_d;
            err_sticky_q <= err_sticky_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    // No valid sample history in IDLE, so report the counter's reset value
    assign trk.expected   = (state_q == IDLE) ? MIN_L : pred;
    assign trk.wrap_up    = wrap_up_q;
    assign trk.wrap_dn    = wrap_dn_q;
    assign trk.step_err   = step_err_q;
    assign trk.range_err  = range_err_q;
    assign trk.err_sticky = err_sticky_q;
    assign trk.wrap_cnt   = wrap_cnt_q;
    assign trk.state      = state_q;
endmodule
